// File: rtl/dff_rst_seq.sv
// Reset sequencer feeding the dff: it synchronizes the release of the board reset, holds the dff in reset while things stabilize, and runs soft resets.
// Optional macro DFF_RST_SEQ_EXTEND_EN: a soft request during SOFT restarts the SOFT window.
module dff_rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 10,
    parameter int SOFT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_rst_req,
    output logic       dff_rst,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] soft_cnt
);

    if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
        SOFT_CYCLES < 1 || SOFT_CYCLES > 255) begin : g_param_check
        $error("dff_rst_seq: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_SOFT = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] SOFT_LAST = 8'(SOFT_CYCLES - 1);

    state_t                   state_reg;
    logic [SYNC_STAGES-2:0]   sync_reg;
    logic [7:0]               cnt_reg;
    logic [7:0]               soft_cnt_reg;
    logic                     dff_rst_reg;
    logic                     ready_reg;

    // The chain holds the first SYNC_STAGES-1 stages; the SYNC->HOLD state
    // transition acts as the final stage, so HOLD starts on edge SYNC_STAGES.
    genvar gi;
    for (gi = 0; gi < SYNC_STAGES - 1; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) sync_reg[gi] <= 1'b0;
                else      sync_reg[gi] <= 1'b1;
            end
        end else begin : g_rest
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) sync_reg[gi] <= 1'b0;
                else      sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_SYNC;
            cnt_reg      <= 8'd0;
            soft_cnt_reg <= 8'd0;
            dff_rst_reg  <= 1'b1;
            ready_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_SYNC: begin
                    if (sync_reg[SYNC_STAGES-2]) begin
                        state_reg <= ST_HOLD;
                        cnt_reg   <= 8'd0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_reg   <= ST_RUN;
                        dff_rst_reg <= 1'b0;
                        ready_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (soft_rst_req) begin
                        state_reg   <= ST_SOFT;
                        cnt_reg     <= 8'd0;
                        dff_rst_reg <= 1'b1;
                        ready_reg   <= 1'b0;
                        if (soft_cnt_reg != 8'd255)
                            soft_cnt_reg <= soft_cnt_reg + 8'd1;
                    end
                end
                ST_SOFT: begin
`ifdef DFF_RST_SEQ_EXTEND_EN
                    if (soft_rst_req) begin
                        cnt_reg <= 8'd0;
                    end else if (cnt_reg == SOFT_LAST) begin
                        state_reg   <= ST_RUN;
                        dff_rst_reg <= 1'b0;
                        ready_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
`else
                    if (cnt_reg == SOFT_LAST) begin
                        state_reg   <= ST_RUN;
                        dff_rst_reg <= 1'b0;
                        ready_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
`endif
                end
                default: begin
                    state_reg <= ST_SYNC;
                end
            endcase
        end
    end

    assign dff_rst  = dff_rst_reg;
    assign ready    = ready_reg;
    assign state    = state_reg;
    assign soft_cnt = soft_cnt_reg;

endmodule

// File: tb/tb_dff_rst_seq.sv
// Bench for dff_rst_seq: an edge-counting reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_dff_rst_seq;

    localparam int S = 2;
    localparam int H = 10;
    localparam int SC = 4;
`ifdef DFF_RST_SEQ_EXTEND_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_rst_req;
    logic       dff_rst;
    logic       ready;
    logic [1:0] state;
    logic [7:0] soft_cnt;

    int errors = 0;
    int checks = 0;

    dff_rst_seq #(.SYNC_STAGES(S), .HOLD_CYCLES(H), .SOFT_CYCLES(SC)) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .dff_rst      (dff_rst),
        .ready        (ready),
        .state        (state),
        .soft_cnt     (soft_cnt)
    );

    always #5 clk = ~clk;

    // Model: edges since reset release, remaining soft-reset cycles, accepted soft count.
    int rel_edges = 0;
    int soft_left = 0;
    int scnt = 0;

    always @(posedge clk or negedge rst) begin
        bit in_run;
        bit in_soft;
        if (!rst) begin
            rel_edges = 0;
            soft_left = 0;
            scnt      = 0;
        end else begin
            in_soft = (soft_left > 0);
            in_run  = (rel_edges >= S + H) && !in_soft;
            if (rel_edges < 1000) rel_edges++;
            if (in_soft) begin
                if (EXT && soft_rst_req) soft_left = SC;
                else                     soft_left--;
            end else if (in_run && soft_rst_req) begin
                soft_left = SC;
                if (scnt < 255) scnt++;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int exp_dff;
        int exp_state;
        exp_dff   = (rel_edges >= S + H && soft_left == 0) ? 0 : 1;
        exp_state = (rel_edges < S) ? 0 : (rel_edges < S + H) ? 1 : (soft_left > 0) ? 3 : 2;
        chk("model_dff_rst", int'(dff_rst), exp_dff);
        chk("model_ready", int'(ready), 1 - exp_dff);
        chk("model_state", int'(state), exp_state);
        chk("model_soft_cnt", int'(soft_cnt), scnt);
    end

    // Releases rst mid-cycle after low_cycles edges, then walks edges 1..12.
    task automatic release_seq(input int low_cycles, input int pulse_edge, input int abort_edge);
        rst = 1'b0;
        repeat (low_cycles) @(posedge clk);
        #2 rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == abort_edge) begin
                #1 rst = 1'b0;
                #1;
                chk("abort_dff_rst", int'(dff_rst), 1);
                chk("abort_ready", int'(ready), 0);
                chk("abort_state", int'(state), 0);
                $display("release aborted after edge %0d: dff_rst=%0d state=%0d", k, dff_rst, state);
                return;
            end
            if (k == pulse_edge) soft_rst_req = 1'b1;
            if (k == pulse_edge + 1) soft_rst_req = 1'b0;
            if (k == 11) begin
                chk("edge11_dff_rst", int'(dff_rst), 1);
                chk("edge11_ready", int'(ready), 0);
            end
            if (k == 12) begin
                chk("edge12_dff_rst", int'(dff_rst), 0);
                chk("edge12_ready", int'(ready), 1);
                chk("edge12_state", int'(state), 2);
                chk("edge12_soft_cnt", int'(soft_cnt), 0);
            end
        end
        $display("release done: dff_rst=%0d ready=%0d state=%0d", dff_rst, ready, state);
    endtask

    // Raises soft_rst_req for req_edges edges and counts edges with dff_rst high.
    task automatic do_soft(input int req_edges, output int n);
        soft_rst_req = 1'b1;
        n = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (e >= req_edges) soft_rst_req = 1'b0;
            if (dff_rst) n++;
            else break;
        end
        soft_rst_req = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        soft_rst_req = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("async_rst_dff_rst", int'(dff_rst), 1);
        chk("async_rst_ready", int'(ready), 0);
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_soft_cnt", int'(soft_cnt), 0);
        $display("power-up reset: dff_rst=%0d ready=%0d state=%0d", dff_rst, ready, state);

        release_seq(3, 0, 0);

        do_soft(1, n);
        chk("soft_run_high_cycles", n, 4);
        chk("soft_run_state", int'(state), 2);
        chk("soft_run_soft_cnt", int'(soft_cnt), 1);
        $display("soft in RUN: high=%0d soft_cnt=%0d", n, soft_cnt);

        rst = 1'b0;
        #1;
        chk("async_run_dff_rst", int'(dff_rst), 1);
        chk("async_run_soft_cnt", int'(soft_cnt), 0);
        $display("async reset in RUN: dff_rst=%0d soft_cnt=%0d", dff_rst, soft_cnt);

        release_seq(2, 0, 7);
        release_seq(2, 5, 0);

        do_soft(2, n);
        chk("soft_in_soft_high_cycles", n, EXT ? 5 : 4);
        chk("soft_in_soft_soft_cnt", int'(soft_cnt), 1);
        $display("soft in SOFT: high=%0d soft_cnt=%0d", n, soft_cnt);

        for (int i = 0; i < 260; i++) begin
            do_soft(1, n);
            chk("sat_high_cycles", n, 4);
            $display("saturation soft %0d: high=%0d soft_cnt=%0d", i, n, soft_cnt);
            @(posedge clk);
            #1;
        end
        chk("sat_soft_cnt", int'(soft_cnt), 255);

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
